sayuru_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single core-memory-protocol slave port of the Sayuru direct-mapped data cache. It sits between two masters (port 0: core LSU, port 1: secondary master such as a trace or DMA unit) and the cache's in_data_* port. Arbitration is round-robin with request locking. A small in-order ID FIFO routes each rvalid/rdata back to the master that issued the transaction.

---
 rtl/sayuru_pkg.sv | 15 +
 rtl/sayuru_id_fifo.sv | 58 +++++
 rtl/sayuru_port_arbiter.sv | 121 ++++++++++++
 tb/tb_sayuru_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sayuru_pkg.sv
// Shared types and constants for the Sayuru cache-port arbiter.
// Requester ID, requester count and arbiter FSM state encoding.
package sayuru_pkg;

    localparam int N_REQ = 2;

    typedef logic req_id_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sayuru_id_fifo.sv
// In-order ID FIFO remembering which master owns each outstanding transaction.
// The head is read combinationally from registered storage, so rvalid can be routed in the same cycle.
module sayuru_id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign head    = mem[rd_ptr_reg];
    assign do_pop  = pop & ~empty;
    // A simultaneous pop frees the slot the push lands in, so push is legal when full.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/sayuru_port_arbiter.sv
// Round-robin, request-locking arbiter sharing the data cache slave port between two masters.
// Responses are steered back to their issuer through an in-order ID FIFO.
module sayuru_port_arbiter
    import sayuru_pkg::*;
#(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    m0_req_i,
    input  logic                    m1_req_i,
    output logic                    m0_gnt_o,
    output logic                    m1_gnt_o,
    output logic                    m0_rvalid_o,
    output logic                    m1_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m0_we_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,
    output logic                    s_req_o,
    input  logic                    s_gnt_i,
    input  logic                    s_rvalid_i,
    output logic [ADDR_WIDTH-1:0]   s_addr_o,
    output logic                    s_we_o,
    output logic [DATA_WIDTH/8-1:0] s_be_o,
    output logic [DATA_WIDTH-1:0]   s_wdata_o,
    input  logic [DATA_WIDTH-1:0]   s_rdata_i,
    output logic                    proto_err_o
);

    arb_state_t       state_reg, state_next;
    req_id_t          rr_last_reg;
    req_id_t          sel;
    logic             proto_err_reg;
    logic [N_REQ-1:0] req_vec;
    logic [N_REQ-1:0] gnt_vec;
    logic [N_REQ-1:0] rvalid_vec;
    logic             sel_req;
    logic             handshake;
    logic             fifo_full;
    logic             fifo_empty;
    req_id_t          fifo_head;

    assign req_vec = {m1_req_i, m0_req_i};

    always_comb begin
        sel        = 1'b0;
        state_next = state_reg;
        case (state_reg)
            LOCK0:   sel = 1'b0;
            LOCK1:   sel = 1'b1;
            default: sel = (&req_vec) ? ~rr_last_reg : req_vec[1];
        endcase
        // Once a winner is stalled, the selection stays frozen until the cache accepts it.
        if (handshake)
            state_next = IDLE;
        else if (state_reg == IDLE && sel_req)
            state_next = sel ? LOCK1 : LOCK0;
    end

    assign sel_req   = req_vec[sel];
    assign s_req_o   = sel_req & ~fifo_full & ~rst;
    assign handshake = s_req_o & s_gnt_i;

    assign s_addr_o  = sel ? m1_addr_i  : m0_addr_i;
    assign s_we_o    = sel ? m1_we_i    : m0_we_i;
    assign s_be_o    = sel ? m1_be_i    : m0_be_i;
    assign s_wdata_o = sel ? m1_wdata_i : m0_wdata_i;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_route
            assign gnt_vec[gi]    = handshake & (sel == req_id_t'(gi));
            assign rvalid_vec[gi] = s_rvalid_i & ~fifo_empty & ~rst & (fifo_head == req_id_t'(gi));
        end
    endgenerate

    assign m0_gnt_o    = gnt_vec[0];
    assign m1_gnt_o    = gnt_vec[1];
    assign m0_rvalid_o = rvalid_vec[0];
    assign m1_rvalid_o = rvalid_vec[1];
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;
    assign proto_err_o = proto_err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            rr_last_reg   <= 1'b1;
            proto_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (handshake)                proto_err_reg <= proto_err_reg;
            if (handshake)                rr_last_reg   <= sel;
            if (s_rvalid_i && fifo_empty) proto_err_reg <= 1'b1;
        end
    end

    sayuru_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (1)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (handshake),
        .din   (sel),
        .pop   (s_rvalid_i),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

endmodule

// File: tb/tb_sayuru_port_arbiter.sv
// Directed-vector bench for sayuru_port_arbiter with hand-computed expectations.
module tb_sayuru_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req_i, m1_req_i;
    logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
    logic [15:0] m0_addr_i, m1_addr_i;
    logic        m0_we_i, m1_we_i;
    logic [3:0]  m0_be_i, m1_be_i;
    logic [31:0] m0_wdata_i, m1_wdata_i, m0_rdata_o, m1_rdata_o;
    logic        s_req_o, s_gnt_i, s_rvalid_i, s_we_o;
    logic [15:0] s_addr_o;
    logic [3:0]  s_be_o;
    logic [31:0] s_wdata_o, s_rdata_i;
    logic        proto_err_o;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    sayuru_port_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req_i), .m1_req_i(m1_req_i),
        .m0_gnt_o(m0_gnt_o), .m1_gnt_o(m1_gnt_o),
        .m0_rvalid_o(m0_rvalid_o), .m1_rvalid_o(m1_rvalid_o),
        .m0_addr_i(m0_addr_i), .m1_addr_i(m1_addr_i),
        .m0_we_i(m0_we_i), .m1_we_i(m1_we_i),
        .m0_be_i(m0_be_i), .m1_be_i(m1_be_i),
        .m0_wdata_i(m0_wdata_i), .m1_wdata_i(m1_wdata_i),
        .m0_rdata_o(m0_rdata_o), .m1_rdata_o(m1_rdata_o),
        .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i),
        .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_wdata_o(s_wdata_o),
        .s_rdata_i(s_rdata_i), .proto_err_o(proto_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        m0_req_i = 1'b1; m1_req_i = 1'b0;
        m0_addr_i = 16'h0010; m1_addr_i = 16'h0000;
        m0_we_i = 1'b0; m1_we_i = 1'b1;
        m0_be_i = 4'hF; m1_be_i = 4'h3;
        m0_wdata_i = 32'hA0A0A0A0; m1_wdata_i = 32'hB1B1B1B1;
        s_gnt_i = 1'b1; s_rvalid_i = 1'b0; s_rdata_i = '0;
        settle();
        chk("rst_s_req", s_req_o, 0);
        chk("rst_m0_gnt", m0_gnt_o, 0);
        chk("rst_proto_err", proto_err_o, 0);
        m0_req_i = 1'b0; s_gnt_i = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();

        // Single m0 read granted in the same cycle
        m0_req_i = 1'b1; s_gnt_i = 1'b1;
        settle();
        $display("txn: m0 req addr 0010 granted");
        chk("t1_s_req", s_req_o, 1);
        chk("t1_s_addr", s_addr_o, 32'h0010);
        chk("t1_s_be", s_be_o, 32'hF);
        chk("t1_m0_gnt", m0_gnt_o, 1);
        chk("t1_m1_gnt", m1_gnt_o, 0);
        cyc();
        m0_req_i = 1'b0; s_gnt_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'hDEADBEEF;
        settle();
        $display("txn: rvalid DEADBEEF to m0");
        chk("t2_m0_rvalid", m0_rvalid_o, 1);
        chk("t2_m1_rvalid", m1_rvalid_o, 0);
        chk("t2_m0_rdata", m0_rdata_o, 32'hDEADBEEF);
        cyc();

        // Lock: m1 stalled 3 cycles while m0 joins in cycle 2
        s_rvalid_i = 1'b0; m1_req_i = 1'b1; m1_addr_i = 16'h0200; m0_addr_i = 16'h0100;
        settle();
        $display("txn: m1 req stalled c1");
        chk("lk1_s_addr", s_addr_o, 32'h0200);
        chk("lk1_s_we", s_we_o, 1);
        chk("lk1_m1_gnt", m1_gnt_o, 0);
        cyc();
        m0_req_i = 1'b1;
        settle();
        $display("txn: m1 req stalled c2, m0 req");
        chk("lk2_s_addr", s_addr_o, 32'h0200);
        chk("lk2_m0_gnt", m0_gnt_o, 0);
        cyc();
        settle();
        $display("txn: m1 req stalled c3");
        chk("lk3_s_addr", s_addr_o, 32'h0200);
        cyc();
        s_gnt_i = 1'b1;
        settle();
        $display("txn: m1 granted after lock");
        chk("lk4_m1_gnt", m1_gnt_o, 1);
        chk("lk4_m0_gnt", m0_gnt_o, 0);
        cyc();
        m1_req_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'h11111111;
        settle();
        $display("txn: m0 granted, m1 rvalid");
        chk("lk5_m0_gnt", m0_gnt_o, 1);
        chk("lk5_s_addr", s_addr_o, 32'h0100);
        chk("lk5_m1_rvalid", m1_rvalid_o, 1);
        chk("lk5_m0_rvalid", m0_rvalid_o, 0);
        cyc();
        m0_req_i = 1'b0; s_gnt_i = 1'b0; s_rdata_i = 32'h22222222;
        settle();
        $display("txn: m0 rvalid");
        chk("lk6_m0_rvalid", m0_rvalid_o, 1);
        chk("lk6_m1_rvalid", m1_rvalid_o, 0);
        cyc();

        // Fairness: last grant went to m0, so m1 wins the first tie, then alternate
        m0_req_i = 1'b1; m1_req_i = 1'b1; s_gnt_i = 1'b1; s_rvalid_i = 1'b0;
        settle();
        $display("txn: both req, grant m1");
        chk("rr1_m1_gnt", m1_gnt_o, 1);
        chk("rr1_m0_gnt", m0_gnt_o, 0);
        chk("rr1_s_addr", s_addr_o, 32'h0200);
        cyc();
        s_rvalid_i = 1'b1; s_rdata_i = 32'h33333333;
        settle();
        $display("txn: both req, grant m0, rvalid m1");
        chk("rr2_m0_gnt", m0_gnt_o, 1);
        chk("rr2_m1_gnt", m1_gnt_o, 0);
        chk("rr2_m1_rvalid", m1_rvalid_o, 1);
        cyc();
        s_rdata_i = 32'h44444444;
        settle();
        $display("txn: both req, grant m1, rvalid m0");
        chk("rr3_m1_gnt", m1_gnt_o, 1);
        chk("rr3_m0_rvalid", m0_rvalid_o, 1);
        chk("rr3_m1_rvalid", m1_rvalid_o, 0);
        cyc();
        settle();
        $display("txn: both req, grant m0, rvalid m1");
        chk("rr4_m0_gnt", m0_gnt_o, 1);
        chk("rr4_m1_rvalid", m1_rvalid_o, 1);
        cyc();
        m0_req_i = 1'b0; m1_req_i = 1'b0; s_gnt_i = 1'b0;
        settle();
        $display("txn: drain rvalid m0");
        chk("rr5_m0_rvalid", m0_rvalid_o, 1);
        cyc();

        // Fill both slots, then check full gating and push+pop occupancy
        s_rvalid_i = 1'b0; m0_req_i = 1'b1; s_gnt_i = 1'b1;
        settle();
        $display("txn: m0 grant slot 1");
        chk("f1_m0_gnt", m0_gnt_o, 1);
        cyc();
        m0_addr_i = 16'h0104;
        settle();
        $display("txn: m0 grant slot 2");
        chk("f2_m0_gnt", m0_gnt_o, 1);
        cyc();
        m0_req_i = 1'b0; m1_req_i = 1'b1; m1_addr_i = 16'h0208;
        settle();
        $display("txn: full, m1 blocked");
        chk("f3_s_req", s_req_o, 0);
        chk("f3_m1_gnt", m1_gnt_o, 0);
        cyc();
        s_rvalid_i = 1'b1; s_rdata_i = 32'h55555555;
        settle();
        $display("txn: full at start, pop m0");
        chk("f4_s_req", s_req_o, 0);
        chk("f4_m0_rvalid", m0_rvalid_o, 1);
        cyc();
        s_rdata_i = 32'h66666666;
        settle();
        $display("txn: push m1 + pop m0");
        chk("f5_m1_gnt", m1_gnt_o, 1);
        chk("f5_m0_rvalid", m0_rvalid_o, 1);
        chk("f5_m0_rdata", m0_rdata_o, 32'h66666666);
        cyc();
        m1_req_i = 1'b0; m0_req_i = 1'b1; m0_addr_i = 16'h010C; s_rvalid_i = 1'b0;
        settle();
        $display("txn: occupancy 1, m0 grant");
        chk("f6_m0_gnt", m0_gnt_o, 1);
        cyc();
        settle();
        $display("txn: full again, m0 blocked");
        chk("f7_s_req", s_req_o, 0);
        cyc();
        s_gnt_i = 1'b0; s_rvalid_i = 1'b1;
        settle();
        $display("txn: pop m1 while m0 locked");
        chk("f8_m1_rvalid", m1_rvalid_o, 1);
        chk("f8_s_req", s_req_o, 0);
        cyc();
        s_gnt_i = 1'b1;
        settle();
        $display("txn: m0 grant + pop m0");
        chk("f9_m0_gnt", m0_gnt_o, 1);
        chk("f9_m0_rvalid", m0_rvalid_o, 1);
        cyc();
        m0_req_i = 1'b0; s_gnt_i = 1'b0;
        settle();
        $display("txn: drain m0");
        chk("f10_m0_rvalid", m0_rvalid_o, 1);
        cyc();

        // rvalid with nothing outstanding
        settle();
        $display("txn: stray rvalid");
        chk("pe1_m0_rvalid", m0_rvalid_o, 0);
        chk("pe1_m1_rvalid", m1_rvalid_o, 0);
        chk("pe1_proto_err", proto_err_o, 0);
        cyc();
        s_rvalid_i = 1'b0;
        settle();
        chk("pe2_proto_err", proto_err_o, 1);
        cyc();
        cyc();
        chk("pe3_proto_err_sticky", proto_err_o, 1);

        // Reset clears the error, then reset mid-transaction discards outstanding IDs
        rst = 1'b1;
        settle();
        $display("txn: reset clears proto_err");
        chk("rs1_proto_err", proto_err_o, 0);
        cyc();
        rst = 1'b0;
        cyc();
        m0_req_i = 1'b1; s_gnt_i = 1'b1;
        settle();
        $display("txn: m0 grant before reset");
        chk("rs2_m0_gnt", m0_gnt_o, 1);
        cyc();
        m0_req_i = 1'b0; s_gnt_i = 1'b0; rst = 1'b1; s_rvalid_i = 1'b1;
        settle();
        $display("txn: rvalid during reset");
        chk("rs3_m0_rvalid", m0_rvalid_o, 0);
        chk("rs3_s_req", s_req_o, 0);
        cyc();
        rst = 1'b0; s_rvalid_i = 1'b0;
        settle();
        chk("rs4_proto_err", proto_err_o, 0);
        chk("rs4_m0_gnt", m0_gnt_o, 0);
        cyc();
        s_rvalid_i = 1'b1;
        settle();
        $display("txn: late rvalid after reset");
        chk("rs5_m0_rvalid", m0_rvalid_o, 0);
        cyc();
        s_rvalid_i = 1'b0;
        settle();
        chk("rs6_proto_err", proto_err_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
